// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor with valid/ready handshakes on both sides.
// Optional build macro SM_SATURATE_EN: overflowed magnitudes clamp to 2^N-1 instead of wrapping.
module sm_addsub_pipe #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N:0]   X,
    input  logic [N:0]   Y,
    input  logic         minEn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   Res,
    output logic         ovf
);

    // Sign-magnitude to N+2-bit two's complement; -0 maps naturally to 0.
    function automatic logic [N+1:0] smToTwos(input logic [N:0] sm);
        logic [N+1:0] magExt;
        magExt = {2'b00, sm[N-1:0]};
        if (sm[N]) begin
            smToTwos = -magExt;
        end else begin
            smToTwos = magExt;
        end
    endfunction

    // Two's-complement sum to {ovf, sign, magnitude}; a zero magnitude never carries a sign.
    function automatic logic [N+1:0] twosToSm(input logic [N+1:0] sum);
        logic [N+1:0] absVal;
        logic [N-1:0] mag;
        logic         ovfBit;
        if (sum[N+1]) begin
            absVal = -sum;
        end else begin
            absVal = sum;
        end
        ovfBit = absVal[N] | absVal[N+1];
`ifdef SM_SATURATE_EN
        if (ovfBit) begin
            mag = {N{1'b1}};
        end else begin
            mag = absVal[N-1:0];
        end
`else
        mag = absVal[N-1:0];
`endif
        twosToSm = {ovfBit, sum[N+1] & (|mag), mag};
    endfunction

    logic             s1Valid_r;
    logic [N+1:0]     s1Sum_r;
    logic             outValid_r;
    logic [N:0]       res_r;
    logic             ovf_r;

    logic             s1Adv_s;
    logic             inReady_s;
    logic             accept_s;
    logic [N+1:0]     xTwos_s;
    logic [N+1:0]     yTwos_s;
    logic [N+1:0]     sumNext_s;
    logic [N+1:0]     smRes_s;

    // Handshake control: S1 drains whenever S2 is empty or being consumed.
    always_comb begin
        s1Adv_s   = 1'b0;
        inReady_s = 1'b0;
        accept_s  = 1'b0;
        if (s1Valid_r && (!outValid_r || out_ready)) begin
            s1Adv_s = 1'b1;
        end else begin
            s1Adv_s = 1'b0;
        end
        inReady_s = !s1Valid_r || s1Adv_s;
        accept_s  = in_valid && inReady_s;
    end

    // Stage-1 datapath: signed X plus (optionally negated) signed Y.
    always_comb begin
        xTwos_s   = smToTwos(X);
        yTwos_s   = '0;
        if (minEn) begin
            yTwos_s = -smToTwos(Y);
        end else begin
            yTwos_s = smToTwos(Y);
        end
        sumNext_s = xTwos_s + yTwos_s;
    end

    // Stage-2 conversion back to sign-magnitude.
    always_comb begin
        smRes_s = twosToSm(s1Sum_r);
    end

    // Stage-1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_r <= 1'b0;
            s1Sum_r   <= '0;
        end else if (accept_s) begin
            s1Valid_r <= 1'b1;
            s1Sum_r   <= sumNext_s;
        end else if (s1Adv_s) begin
            s1Valid_r <= 1'b0;
        end
    end

    // Stage-2 output register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_r <= 1'b0;
            res_r      <= '0;
            ovf_r      <= 1'b0;
        end else if (s1Adv_s) begin
            outValid_r <= 1'b1;
            res_r      <= smRes_s[N:0];
            ovf_r      <= smRes_s[N+1];
        end else if (out_ready) begin
            outValid_r <= 1'b0;
        end
    end

    assign in_ready  = inReady_s;
    assign out_valid = outValid_r;
    assign Res       = res_r;
    assign ovf       = ovf_r;

endmodule

// File: doc/sm_addsub_pipe.md
SM_ADDSUB_PIPE -- requirements
Module: sm_addsub_pipe

Interface
REQ-001 SHALL have parameter N, default 8, giving the magnitude width; operand/result words are N+1 bits, bit N = sign (1 = negative), bits N-1:0 = magnitude.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair present.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port X  input  N+1  first operand, sign-magnitude.
REQ-007 SHALL have port Y  input  N+1  second operand, sign-magnitude.
REQ-008 SHALL have port minEn  input  1  1 = X-Y, 0 = X+Y.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port Res  output  N+1  result, sign-magnitude.
REQ-012 SHALL have port ovf  output  1  true result magnitude exceeded 2^N-1; qualified by out_valid.

Function
REQ-013 SHALL accept an operation on a cycle with in_valid=1 and in_ready=1; transfer out on out_valid=1 and out_ready=1.
REQ-014 SHALL be a two-stage pipeline: S1 registers the N+2-bit two's-complement sum of signed X and (minEn ? -Y : Y); S2 registers Res/ovf in sign-magnitude.
REQ-015 SHALL present the result with out_valid two cycles after acceptance when not stalled; sustained throughput one operation per cycle.
REQ-016 SHALL drive in_ready = !S1_valid or S1 advancing; S1 advances when !S2_valid or out_ready=1 (combinational ready path, no bubble).
REQ-017 SHALL hold Res, ovf, out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL treat -0 (sign 1, magnitude 0) on X or Y as zero.
REQ-019 SHALL never output -0: zero result always has sign bit 0.
REQ-020 SHALL set sign of nonzero result to sign of the two's-complement sum; magnitude = absolute value of the sum.
REQ-021 SHALL set ovf=1 when |sum| > 2^N-1; otherwise ovf=0.
REQ-022 SHALL, on simultaneous accept into S1 and S1->S2 advance and S2 output transfer, perform all three in the same cycle without data loss or duplication.
REQ-023 SHALL ignore X, Y, minEn when not accepted.

Reset
REQ-024 SHALL on rst=1 immediately clear S1_valid, S2_valid, out_valid=0, Res=0, ovf=0, independent of clk.
REQ-025 SHALL discard any in-flight operations on reset; in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL use macro SM_SATURATE_EN: when defined, overflowed result magnitude saturates to 2^N-1 with computed sign.
REQ-027 SHALL, when SM_SATURATE_EN undefined, output magnitude = |sum| mod 2^N with computed sign (zero after wrap forced to +0); ovf behaviour identical in both builds.

Verification (N=8)
REQ-028 SHALL verify X=0x005, Y=0x103 (-3), minEn=0 -> Res=0x002, ovf=0, out_valid exactly 2 cycles after accept.
REQ-029 SHALL verify X=0x003, Y=0x005, minEn=1 -> Res=0x105 is wrong, required Res=0x102 (-2); and X=0x100 (-0), Y=0x000, minEn=1 -> Res=0x000.
REQ-030 SHALL verify X=0x0C8 (200), Y=0x064 (100), minEn=0 -> ovf=1, Res=0x0FF with SM_SATURATE_EN, Res=0x02C without; X=0x1C8, Y=0x064, minEn=1 -> ovf=1, Res=0x1FF / 0x12C.
REQ-031 SHALL verify back-to-back 4 ops with out_ready=0 for 4 cycles -> exactly 2 accepted then in_ready=0, Res held constant; release out_ready -> results emerge in order, one per cycle, none lost.
REQ-032 SHALL verify rst pulse asserted mid-cycle with both stages full -> out_valid=0 and Res=0 before next clk edge; first post-reset op yields correct result after 2 cycles.
